// File: rtl/blink_pattern_rx.sv
// blink_pattern_rx: receive side of the LED blink-pattern link.
// The slow on/off input is synchronized and debounced. A slot timer is
// re-phased on every accepted level change and samples mid-slot. The samples
// shift into a window that is hunted for the expected pattern and then
// re-checked once per frame while locked.
module blink_pattern_rx #(
  parameter int                     TICK_BITS       = 20,
  parameter int                     PATTERN_LEN     = 32,
  parameter logic [PATTERN_LEN-1:0] EXPECTED        = 32'b11110000111100001010101010010110,
  parameter int                     FRAME_SLOTS     = 64,
  parameter int                     DEBOUNCE_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   rx_in,
  output logic                   sample_strobe,
  output logic [PATTERN_LEN-1:0] shift_reg,
  output logic                   locked,
  output logic                   match,
  output logic [7:0]             match_count
);

  localparam int SLOT_W = $clog2(FRAME_SLOTS) + 1;
  localparam int DEB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [DEB_W-1:0]     DEB_LAST     = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TICK_BITS-1:0] SAMPLE_POINT = TICK_BITS'((2 ** (TICK_BITS - 1)) - 1);
  localparam logic [SLOT_W-1:0]    SLOT_FULL    = SLOT_W'(FRAME_SLOTS);
  localparam logic [SLOT_W-1:0]    PAT_SLOTS    = SLOT_W'(PATTERN_LEN);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HUNT,
    ST_LOCKED
  } state_t;

  state_t               state;
  logic                 sync_a;
  logic                 sync_b;
  logic                 filt_level;
  logic [DEB_W-1:0]     deb_cnt;
  logic [TICK_BITS-1:0] timer;
  logic [SLOT_W-1:0]    slot_cnt;
  logic                 check_pending;

  logic                 rx_edge;
  logic                 sample_pt;
  logic [SLOT_W-1:0]    slot_inc;

  // The filtered level flips in the same cycle this is high, so it doubles
  // as the slot-timer resync event.
  assign rx_edge   = (sync_b != filt_level) && (deb_cnt == DEB_LAST);
  // An edge on the sample point wins: the slot is re-phased instead.
  assign sample_pt = (state != ST_IDLE) && !rx_edge && (timer == SAMPLE_POINT);
  assign slot_inc  = (slot_cnt == SLOT_FULL) ? slot_cnt : slot_cnt + SLOT_W'(1);

  // Input synchronizer and debounce filter; independent of enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a     <= 1'b0;
      sync_b     <= 1'b0;
      filt_level <= 1'b0;
      deb_cnt    <= '0;
    end else begin
      sync_a <= rx_in;
      sync_b <= sync_a;
      if (sync_b == filt_level) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        filt_level <= ~filt_level;
        deb_cnt    <= '0;
      end else begin
        deb_cnt <= deb_cnt + DEB_W'(1);
      end
    end
  end

  // Receiver FSM: slot timing, sample window, pattern compare and lock tracking.
  // A compare is scheduled on the sample and evaluated one cycle later on the
  // updated window, so MATCH (or the lock drop) follows SAMPLE_STROBE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      timer         <= '0;
      slot_cnt      <= '0;
      shift_reg     <= '0;
      check_pending <= 1'b0;
      sample_strobe <= 1'b0;
      match         <= 1'b0;
      locked        <= 1'b0;
      match_count   <= '0;
    end else begin
      sample_strobe <= 1'b0;
      match         <= 1'b0;
      check_pending <= 1'b0;
      if (!enable) begin
        state     <= ST_IDLE;
        timer     <= '0;
        slot_cnt  <= '0;
        shift_reg <= '0;
        locked    <= 1'b0;
      end else if (state == ST_IDLE) begin
        timer    <= '0;
        slot_cnt <= '0;
        if (rx_edge) begin
          state <= ST_HUNT;
        end
      end else begin
        if (rx_edge) begin
          timer <= '0;
        end else begin
          timer <= timer + TICK_BITS'(1);
        end

        if (sample_pt) begin
          sample_strobe <= 1'b1;
          shift_reg     <= {filt_level, shift_reg[PATTERN_LEN-1:1]};
          slot_cnt      <= slot_inc;
          if (state == ST_HUNT) begin
            check_pending <= (slot_inc >= PAT_SLOTS);
          end else begin
            check_pending <= (slot_inc == SLOT_FULL);
          end
        end

        if (check_pending) begin
          if (shift_reg == EXPECTED) begin
            match    <= 1'b1;
            state    <= ST_LOCKED;
            locked   <= 1'b1;
            slot_cnt <= '0;
            if (match_count != 8'hFF) begin
              match_count <= match_count + 8'd1;
            end
          end else if (state == ST_LOCKED) begin
            state    <= ST_HUNT;
            locked   <= 1'b0;
            slot_cnt <= '0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_blink_pattern_rx.sv
// tb_blink_pattern_rx: directed frame table plus hand-written sequences for
// reset, disable and asynchronous reset of blink_pattern_rx.
module tb_blink_pattern_rx;

  localparam logic [31:0] EXP = 32'b11110000111100001010101010010110;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        rx_in;
  logic        sample_strobe;
  logic [31:0] shift_reg;
  logic        locked;
  logic        match;
  logic [7:0]  match_count;

  int checks = 0;
  int errors = 0;

  int strobe_seen = 0;
  int match_seen = 0;
  int last_match_strobe = 0;
  logic prev_strobe = 1'b0;
  logic prev_match = 1'b0;
  logic prev_locked = 1'b0;

  blink_pattern_rx #(
    .TICK_BITS(4),
    .PATTERN_LEN(32),
    .EXPECTED(EXP),
    .FRAME_SLOTS(64),
    .DEBOUNCE_CYCLES(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .rx_in(rx_in),
    .sample_strobe(sample_strobe),
    .shift_reg(shift_reg),
    .locked(locked),
    .match(match),
    .match_count(match_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input bit ok, input string name, input longint act, input longint req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endfunction

  // Cycle monitor: pulse shapes, match timing and frame spacing.
  always @(negedge clk) begin
    if (sample_strobe) begin
      strobe_seen++;
      chk(!prev_strobe, "strobe_not_back_to_back", prev_strobe, 0);
    end
    if (match) begin
      match_seen++;
      chk(prev_strobe, "match_follows_strobe", prev_strobe, 1);
      chk(shift_reg == EXP, "window_at_match", shift_reg, EXP);
      chk(!prev_match, "match_not_back_to_back", prev_match, 0);
      if (prev_locked) begin
        chk(strobe_seen - last_match_strobe == 64, "samples_between_matches",
            strobe_seen - last_match_strobe, 64);
      end
      last_match_strobe = strobe_seen;
    end
    if (prev_locked && !locked && enable && rst_n) begin
      chk(prev_strobe, "unlock_follows_strobe", prev_strobe, 1);
    end
    prev_strobe = sample_strobe;
    prev_match  = match;
    prev_locked = locked;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] pat;
    bit          drift;
    bit          glitch;
    int          exp_matches;
    bit          exp_locked;
    int          exp_count;
  } frame_vec_t;

  frame_vec_t vecs[8];

  // Hold one slot level for len cycles, optionally with a 1-cycle glitch mid-slot.
  task automatic drive_slot(input logic v, input int len, input bit glitch);
    rx_in = v;
    for (int c = 0; c < len; c++) begin
      if (glitch && c == 8) rx_in = ~v;
      if (glitch && c == 9) rx_in = v;
      @(negedge clk);
    end
  endtask

  // One frame: 32 pattern slots LSB first, then 32 zero slots.
  task automatic drive_frame(input logic [31:0] pat, input bit drift, input bit glitch);
    int len;
    for (int i = 0; i < 64; i++) begin
      len = drift ? ((i % 2 == 0) ? 15 : 17) : 16;
      drive_slot((i < 32) ? pat[i] : 1'b0, len, glitch);
      if (i == 31) chk(shift_reg == pat, "window_after_pattern", shift_reg, pat);
    end
  endtask

  task automatic run_frame_checked(input frame_vec_t v, input string tag);
    int m0;
    int s0;
    m0 = match_seen;
    s0 = strobe_seen;
    drive_frame(v.pat, v.drift, v.glitch);
    chk(match_seen - m0 == v.exp_matches, {tag, "_matches"}, match_seen - m0, v.exp_matches);
    chk(strobe_seen - s0 == 64, {tag, "_samples"}, strobe_seen - s0, 64);
    chk(locked == v.exp_locked, {tag, "_locked"}, locked, v.exp_locked);
    chk(match_count == 8'(v.exp_count), {tag, "_match_count"}, match_count, v.exp_count);
  endtask

  initial begin
    int s0;
    int m0;
    frame_vec_t extra;

    vecs[0] = '{EXP,             1'b0, 1'b0, 1, 1'b1, 1};
    vecs[1] = '{EXP,             1'b0, 1'b0, 1, 1'b1, 2};
    vecs[2] = '{EXP,             1'b0, 1'b0, 1, 1'b1, 3};
    vecs[3] = '{EXP,             1'b0, 1'b1, 1, 1'b1, 4};
    vecs[4] = '{EXP ^ 32'h20,    1'b0, 1'b0, 0, 1'b0, 4};
    vecs[5] = '{EXP,             1'b0, 1'b0, 1, 1'b1, 5};
    vecs[6] = '{EXP,             1'b1, 1'b0, 1, 1'b1, 6};
    vecs[7] = '{EXP,             1'b1, 1'b0, 1, 1'b1, 7};

    // Reset with a toggling input: everything stays cleared.
    rst_n  = 1'b0;
    enable = 1'b0;
    rx_in  = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      rx_in = ~rx_in;
    end
    rx_in = 1'b0;
    repeat (4) @(negedge clk);
    chk(sample_strobe == 1'b0, "reset_strobe", sample_strobe, 0);
    chk(match == 1'b0, "reset_match", match, 0);
    chk(locked == 1'b0, "reset_locked", locked, 0);
    chk(shift_reg == 32'h0, "reset_shift", shift_reg, 0);
    chk(match_count == 8'd0, "reset_count", match_count, 0);

    // Enabled with a static input: no edge, so the receiver stays idle.
    enable = 1'b1;
    rst_n  = 1'b1;
    repeat (200) @(negedge clk);
    chk(strobe_seen == 0, "idle_no_strobe", strobe_seen, 0);
    chk(locked == 1'b0, "idle_locked", locked, 0);

    // One high preamble slot so the first pattern bit (a 0) is an edge.
    drive_slot(1'b1, 16, 1'b0);

    for (int f = 0; f < 8; f++) begin
      run_frame_checked(vecs[f], $sformatf("frame%0d", f));
    end

    // Disable at slot 10 of a locked frame.
    for (int i = 0; i < 10; i++) drive_slot(EXP[i], 16, 1'b0);
    rx_in  = EXP[10];
    enable = 1'b0;
    @(negedge clk);
    chk(shift_reg == 32'h0, "disable_shift", shift_reg, 0);
    chk(locked == 1'b0, "disable_locked", locked, 0);
    chk(match_count == 8'd7, "disable_count", match_count, 7);
    s0 = strobe_seen;
    m0 = match_seen;
    drive_slot(1'b1, 16, 1'b0);
    drive_slot(1'b0, 16, 1'b0);
    drive_slot(1'b1, 16, 1'b0);
    drive_slot(1'b0, 32, 1'b0);
    chk(strobe_seen == s0, "disabled_no_strobe", strobe_seen - s0, 0);
    chk(match_seen == m0, "disabled_no_match", match_seen - m0, 0);

    // Re-enable and relock on a fresh frame.
    enable = 1'b1;
    repeat (50) @(negedge clk);
    chk(strobe_seen == s0, "reenable_idle", strobe_seen - s0, 0);
    drive_slot(1'b1, 16, 1'b0);
    extra = '{EXP, 1'b0, 1'b0, 1, 1'b1, 8};
    run_frame_checked(extra, "relock");

    // Asynchronous reset in the middle of a slot, away from any clock edge.
    for (int i = 0; i < 5; i++) drive_slot(EXP[i], 16, 1'b0);
    rx_in = EXP[5];
    repeat (6) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk(locked == 1'b0, "async_rst_locked", locked, 0);
    chk(match_count == 8'd0, "async_rst_count", match_count, 0);
    chk(shift_reg == 32'h0, "async_rst_shift", shift_reg, 0);
    chk(sample_strobe == 1'b0, "async_rst_strobe", sample_strobe, 0);
    chk(match == 1'b0, "async_rst_match", match, 0);
    s0 = strobe_seen;
    m0 = match_seen;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      rx_in = ~rx_in;
    end
    chk(strobe_seen == s0, "in_reset_no_strobe", strobe_seen - s0, 0);
    chk(match_seen == m0, "in_reset_no_match", match_seen - m0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
